// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder: computes {cout, sum} = a + b + cin one bit per clock,
//   LSB first, through a single full-adder slice with a registered carry.
//   A start pulse in IDLE captures the operands. WIDTH edges later the result
//   is published together with a one-cycle done pulse.
//
// Parameters
//   WIDTH  operand / sum width in bits (1..32)
//
// Ports
//   clk    in   system clock, rising edge active
//   rst    in   asynchronous active-high reset
//   start  in   request a new addition (sampled only while idle)
//   a, b   in   WIDTH-bit operands, captured on the accepted start edge
//   cin    in   carry-in, captured on the accepted start edge
//   busy   out  high while an addition is in progress
//   done   out  one-cycle pulse, sum/cout valid
//   sum    out  WIDTH-bit result, held until the next run completes
//   cout   out  final carry-out, held with sum
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter must be able to hold WIDTH (its value after the last edge).
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Carry out of a full-adder slice.
    function automatic logic fa_majority(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic             carry_q,  carry_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;

    logic             bit_s;
    logic             carry_s;
    logic [WIDTH-1:0] res_shift_s;

    // Full-adder slice on the current LSBs and the registered carry.
    assign bit_s   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign carry_s = fa_majority(a_sr_q[0], b_sr_q[0], carry_q);

    // New sum bit enters at the MSB; written as a widened shift so that
    // WIDTH=1 needs no empty part-select.
    assign res_shift_s = WIDTH'({bit_s, res_sr_q} >> 1'b1);

    // Next-state and datapath update logic.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sum_d    = sum_q;
        cout_d   = cout_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    a_sr_d   = a;
                    b_sr_d   = b;
                    carry_d  = cin;
                    cnt_d    = CW'(0);
                    busy_d   = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                // start is deliberately not looked at here: runs cannot be restarted.
                a_sr_d   = a_sr_q >> 1'b1;
                b_sr_d   = b_sr_q >> 1'b1;
                res_sr_d = res_shift_s;
                carry_d  = carry_s;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_IDLE;
                    sum_d   = res_shift_s;
                    cout_d  = carry_s;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
